// File: rtl/imm_pkg.sv
// Shared constants for the decode-stage immediate generator.
package imm_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    SEL_I     = 3'd0,
    SEL_S     = 3'd1,
    SEL_U     = 3'd2,
    SEL_B     = 3'd3,
    SEL_J     = 3'd4,
    SEL_Z     = 3'd5,
    SEL_SHAMT = 3'd6,
    SEL_RSVD  = 3'd7
  } imm_sel_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/imm_field_decode.sv
// Combinational immediate extraction and extension for one instruction word.
module imm_field_decode
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instruction,
  input  logic [2:0]      select,
  output logic [XLEN-1:0] imm,
  output logic            sel_err
);

  logic [31:0] imm32;
  logic        sext;
  logic        unused_opcode;

  // The opcode field never influences the result; mode comes from select alone.
  assign unused_opcode = ^instruction[6:0];

  // Build a 32-bit immediate, then widen it with or without sign extension.
  always_comb begin
    imm32   = '0;
    sext    = 1'b0;
    sel_err = 1'b0;
    case (imm_sel_e'(select))
      SEL_I: begin
        imm32 = {{20{instruction[31]}}, instruction[31:20]};
        sext  = 1'b1;
      end
      SEL_S: begin
        imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        sext  = 1'b1;
      end
      SEL_U: begin
        imm32 = {instruction[31:12], 12'b0};
        sext  = 1'b1;
      end
      SEL_B: begin
        imm32 = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                 instruction[11:8], 1'b0};
        sext  = 1'b1;
      end
      SEL_J: begin
        imm32 = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                 instruction[30:21], 1'b0};
        sext  = 1'b1;
      end
      SEL_Z: begin
        imm32 = {27'b0, instruction[19:15]};
      end
      SEL_SHAMT: begin
        // RV64 shifts carry a 6-bit amount, RV32 only 5 bits.
        imm32 = (XLEN == 64) ? {26'b0, instruction[25:20]}
                             : {27'b0, instruction[24:20]};
      end
      default: begin
        imm32   = '0;
        sel_err = 1'b1;
      end
    endcase
    imm       = {XLEN{sext & imm32[31]}};
    imm[31:0] = imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with PC-relative target and a two-entry skid buffer.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | no entry held, output invalid
// ST_BUSY  | main register holds the oldest entry
// ST_FULL  | main and skid registers both hold entries
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [2:0]      select,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] target,
  output logic            sel_err
);

  buf_state_e      state;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;
  logic            dec_err;
  logic [XLEN-1:0] skid_imm;
  logic [XLEN-1:0] skid_target;
  logic            skid_err;
  logic            accept;

  imm_field_decode #(.XLEN(XLEN)) u_decode (
    .instruction (instruction),
    .select      (select),
    .imm         (dec_imm),
    .sel_err     (dec_err)
  );

  // Target add happens before the main register so output latency stays at one cycle.
  assign dec_target = pc + dec_imm;

  // Ready depends only on registered state and reset, never on out_ready.
  assign in_ready = (state != ST_FULL) && !reset;
  assign accept   = in_valid && in_ready;

  // Buffer control: main register drives the outputs, skid catches the entry
  // that arrives while the output is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_EMPTY;
      out_valid   <= 1'b0;
      imm         <= '0;
      target      <= '0;
      sel_err     <= 1'b0;
      skid_imm    <= '0;
      skid_target <= '0;
      skid_err    <= 1'b0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            imm       <= dec_imm;
            target    <= dec_target;
            sel_err   <= dec_err;
            out_valid <= 1'b1;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept && !out_ready) begin
            skid_imm    <= dec_imm;
            skid_target <= dec_target;
            skid_err    <= dec_err;
            state       <= ST_FULL;
          end else if (accept) begin
            imm     <= dec_imm;
            target  <= dec_target;
            sel_err <= dec_err;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            imm     <= skid_imm;
            target  <= skid_target;
            sel_err <= skid_err;
            state   <= ST_BUSY;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule
